// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external combinational ALU
// between two requesters. Each transaction runs IDLE -> EXEC -> RESP. The
// result is held in a per-requester response register until it is consumed.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  output logic             resp0_neg,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  output logic             resp1_neg,
  // shared ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;          // round-robin priority pointer
  logic             gnt_q, gnt_d;          // requester owning the transaction
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             resp0_valid_q, resp0_valid_d;
  logic [WIDTH-1:0] resp0_result_q, resp0_result_d;
  logic             resp0_zero_q, resp0_zero_d;
  logic             resp0_neg_q, resp0_neg_d;
  logic             resp1_valid_q, resp1_valid_d;
  logic [WIDTH-1:0] resp1_result_q, resp1_result_d;
  logic             resp1_zero_q, resp1_zero_d;
  logic             resp1_neg_q, resp1_neg_d;

  logic grant_valid;
  logic grant_id;
  logic resp_done;

  // Grant selection in IDLE; readies are held low while reset is asserted.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr_q;
    if (rst_n && (state_q == IDLE)) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ptr_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid & ~grant_id;
  assign req1_ready = grant_valid &  grant_id;

  // Response handshake only counts for the owner while its result is valid.
  assign resp_done = (state_q == RESP) &&
                     (gnt_q ? (resp1_valid_q && resp1_ready)
                            : (resp0_valid_q && resp0_ready));

  // Next-state and next-output computation; everything holds by default.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = gnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_ctrl_d     = alu_ctrl_q;
    resp0_valid_d  = resp0_valid_q;
    resp0_result_d = resp0_result_q;
    resp0_zero_d   = resp0_zero_q;
    resp0_neg_d    = resp0_neg_q;
    resp1_valid_d  = resp1_valid_q;
    resp1_result_d = resp1_result_q;
    resp1_zero_d   = resp1_zero_q;
    resp1_neg_d    = resp1_neg_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gnt_d      = grant_id;
          alu_a_d    = grant_id ? req1_a  : req0_a;
          alu_b_d    = grant_id ? req1_b  : req0_b;
          alu_ctrl_d = grant_id ? req1_op : req0_op;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (gnt_q) begin
          resp1_valid_d  = 1'b1;
          resp1_result_d = alu_result;
          resp1_zero_d   = alu_zero;
          resp1_neg_d    = alu_neg;
        end else begin
          resp0_valid_d  = 1'b1;
          resp0_result_d = alu_result;
          resp0_zero_d   = alu_zero;
          resp0_neg_d    = alu_neg;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_done) begin
          if (gnt_q) resp1_valid_d = 1'b0;
          else       resp0_valid_d = 1'b0;
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= 1'b0;
      gnt_q          <= 1'b0;
      busy_q         <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= 4'b0000;
      resp0_valid_q  <= 1'b0;
      resp0_result_q <= '0;
      resp0_zero_q   <= 1'b0;
      resp0_neg_q    <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp1_result_q <= '0;
      resp1_zero_q   <= 1'b0;
      resp1_neg_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_q          <= gnt_d;
      busy_q         <= busy_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_ctrl_q     <= alu_ctrl_d;
      resp0_valid_q  <= resp0_valid_d;
      resp0_result_q <= resp0_result_d;
      resp0_zero_q   <= resp0_zero_d;
      resp0_neg_q    <= resp0_neg_d;
      resp1_valid_q  <= resp1_valid_d;
      resp1_result_q <= resp1_result_d;
      resp1_zero_q   <= resp1_zero_d;
      resp1_neg_q    <= resp1_neg_d;
    end
  end

  assign busy         = busy_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign resp0_valid  = resp0_valid_q;
  assign resp0_result = resp0_result_q;
  assign resp0_zero   = resp0_zero_q;
  assign resp0_neg    = resp0_neg_q;
  assign resp1_valid  = resp1_valid_q;
  assign resp1_result = resp1_result_q;
  assign resp1_zero   = resp1_zero_q;
  assign resp1_neg    = resp1_neg_q;

endmodule
